mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped 8N1 UART transmitter on the CPU data bus, in parallel with the unified instruction/data memory.
- Decodes the core's store address; captures stored bytes into a TX FIFO; serialises them onto a single tx pin.
- Gives rv32i test programs a console output. The top-level muxes its read data over the memory read data whenever hit is high.

Parameters:
- BASE_ADDR, 32'h0000_1000, word-aligned base of the 3-register window.
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range is 2 or more.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- we  in  1  store strobe from core (MemWrite).
- addr  in  32  bus byte address.
- wd  in  32  store data.
- hit  out  1  combinational; high when addr[31:4] matches the window and addr[3:2] is 0, 1 or 2.
- rd  out  32  combinational read data; 0 when hit is low.
- tx  out  1  serial line, idle high.

Behaviour:
- Register map (word offsets):
  - +0x0 TXDATA: a write pushes wd[7:0]; a read returns 0.
  - +0x4 STATUS (read): bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[11:8] count (zero-extended). Writing 1 to bit3 clears overflow.
  - +0x8 CTRL: see optional feature.
  - Offset +0xC is not decoded: hit is low.
- Write handling:
  - A write acts only when we and hit are both high; bytes other than [7:0] are ignored.
  - Push is accepted if the FIFO is not full at the start of that cycle.
  - A push while full is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
  - Simultaneous accepted push and pop leaves count unchanged.
- FIFO:
  - count ranges 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
- TX FSM states: IDLE, START, DATA, STOP. A baud counter runs 0..CLKS_PER_BIT-1; each state lasts one full bit period.
  - IDLE: tx=1. If FIFO is not empty, pop the head into shift register sh and go to START on the next edge. This is 1 cycle of latency from write to start bit.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=sh[0], LSB first. At the end of each bit period, shift sh right and increment the index. After index 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE. If FIFO is not empty on that final cycle, pop and go directly to START (back-to-back frames, no idle gap).
- tx is registered, so there are no combinational glitches.
- Reset (asynchronous, any time, including mid-frame):
  - FSM=IDLE, tx=1, count=0, pointers=0, overflow=0, sh=0, baud counter=0, CTRL=0.
  - A partial frame is abandoned; the line returns high immediately.
- Frame length is exactly 10*CLKS_PER_BIT cycles.

Optional Feature:
- Macro: UART_TX_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit, registered, reset 0).
  - CTRL bit0 = ie (read/write); other CTRL bits read 0.
  - irq = ie & empty & (FSM==IDLE), updated each cycle ("transmit drained" interrupt).
- Undefined:
  - No irq port.
  - CTRL reads 0 and writes are ignored; hit still covers +0x8.

Decomposition:
- Package uart_pkg holds:
  - register offsets (OFS_TXDATA=0, OFS_STATUS=4, OFS_CTRL=8);
  - STATUS bit positions;
  - 2-bit FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
- Sub-module: sync_fifo (params WIDTH=8, DEPTH).
  - Ports: push, pop, din, dout, full, empty, count.
  - Push-when-full is ignored inside the FIFO; overflow detection stays in the parent.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=8, BASE_ADDR=0x1000):
- Write 0x55 to 0x1000 at cycle 0 → tx low during cycles 2-5, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, high during cycles 38-41. busy=0 from cycle 42.
- Write 0xA5 then 0x3C on consecutive cycles → two frames back-to-back, total 80 cycles with no idle gap. STATUS count reads 1 right after the second write.
- Write 9 bytes in 9 consecutive cycles → 9 bytes accepted and serialised (the first pops early), overflow=0. Then, while busy, fill the FIFO to 8 entries and write a 9th → STATUS full=1, overflow=1. Write 0x8 to 0x1004 → overflow=0.
- Assert reset_n=0 for 1 cycle mid-DATA of a 0x00 frame → tx=1 immediately, STATUS reads 0x2 (empty only).
- Read 0x100C and 0x2000 → hit=0, rd=0. Read 0x1004 when idle → rd=0x0000_0002.
- With UART_TX_IRQ_EN: write 1 to 0x1008, then send 0x41 → irq=0 while busy, irq=1 one cycle after return to IDLE. Without the macro: 0x1008 reads 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Latency: none (constants and types only).
// Backpressure: not applicable.
//
// Contents: register word offsets, STATUS bit positions, TX FSM state encoding.
package uart_pkg;

    // Byte offsets of the three decoded registers inside the 16-byte window.
    localparam logic [3:0] OFS_TXDATA = 4'h0;
    localparam logic [3:0] OFS_STATUS = 4'h4;
    localparam logic [3:0] OFS_CTRL   = 4'h8;

    // STATUS register layout.
    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_CNT_W   = 4;

    // CTRL register layout (only meaningful when the interrupt is built in).
    localparam int CTRL_IE = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and combinational head output.
// Latency: a pushed entry is visible on dout / counted in the cycle after the push edge.
// Backpressure: push while full is silently ignored; pop while empty is ignored.
//
// Ports: clk, reset_n (async active-low), push/din write side, pop/dout read side,
//        full, empty, count (0..DEPTH).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA are queued and serialised on tx.
// Latency: start bit begins 1 cycle after the byte lands in the FIFO; frame = 10*CLKS_PER_BIT cycles.
// Backpressure: none to the core; a store to a full FIFO is dropped and sets sticky overflow.
//
// Ports: clk, reset_n (async active-low), we/addr/wd store bus, hit/rd combinational
//        read decode, tx serial line (idle high); irq when UART_TX_IRQ_EN is defined.
// Build option: define UART_TX_IRQ_EN to add CTRL.ie and the registered irq output.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic        hit,
    output logic [31:0] rd,
    output logic        tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    import uart_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    // Word selects derived from the byte offsets.
    localparam logic [1:0] SEL_TXDATA = OFS_TXDATA[3:2];
    localparam logic [1:0] SEL_STATUS = OFS_STATUS[3:2];
    localparam logic [1:0] SEL_CTRL   = OFS_CTRL[3:2];

    logic [1:0]    wsel;
    logic          wr_txdata;
    logic          wr_status;
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic [31:0]   status;
    logic          bus_unused;

    tx_state_t     state;
    logic [BW-1:0] baud;
    logic [2:0]    idx;
    logic [7:0]    sh;
    logic          baud_last;

    // Byte lanes and sub-word address bits carry no meaning here.
    assign bus_unused = ^{addr[1:0], wd[31:8]};

    assign wsel      = addr[3:2];
    assign hit       = (addr[31:4] == BASE_ADDR[31:4]) && (wsel != 2'd3);
    assign wr_txdata = we & hit & (wsel == SEL_TXDATA);
    assign wr_status = we & hit & (wsel == SEL_STATUS);
    assign baud_last = (baud == BAUD_LAST);

    // Pop exactly when the FSM loads sh: from IDLE, or on the last STOP cycle
    // so consecutive frames run with no idle gap.
    assign fifo_pop = ~fifo_empty &
                      ((state == IDLE) | ((state == STOP) & baud_last));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_txdata),
        .pop     (fifo_pop),
        .din     (wd[7:0]),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Overflow looks at full from the start of the cycle, so a same-cycle pop
    // does not rescue a store that arrives while the FIFO is full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (wr_txdata & fifo_full) begin
            overflow <= 1'b1;
        end else if (wr_status & wd[STAT_OVF]) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            baud  <= '0;
            idx   <= '0;
            sh    <= '0;
            tx    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud <= '0;
                    tx   <= 1'b1;
                    if (!fifo_empty) begin
                        sh    <= fifo_dout;
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud  <= '0;
                        idx   <= '0;
                        state <= DATA;
                        tx    <= sh[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud <= '0;
                        sh   <= sh >> 1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                            // sh[1] becomes sh[0] after this shift.
                            tx  <= sh[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (!fifo_empty) begin
                            sh    <= fifo_dout;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        status                                   = '0;
        status[STAT_FULL]                        = fifo_full;
        status[STAT_EMPTY]                       = fifo_empty;
        status[STAT_BUSY]                        = (state != IDLE);
        status[STAT_OVF]                         = overflow;
        status[STAT_CNT_LSB +: STAT_CNT_W]       = STAT_CNT_W'(fifo_count);
    end

`ifdef UART_TX_IRQ_EN
    logic ie;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (we & hit & (wsel == SEL_CTRL)) begin
                ie <= wd[CTRL_IE];
            end
            // "Transmit drained": nothing queued and the line has gone idle.
            irq <= ie & fifo_empty & (state == IDLE);
        end
    end

    always_comb begin
        rd = '0;
        if (hit) begin
            case (wsel)
                SEL_STATUS: rd = status;
                SEL_CTRL:   rd[CTRL_IE] = ie;
                default:    rd = '0;
            endcase
        end
    end
`else
    always_comb begin
        rd = '0;
        if (hit && (wsel == SEL_STATUS)) begin
            rd = status;
        end
    end
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        hit;
    logic [31:0] rd;
    logic        tx;
`ifdef UART_TX_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Bytes stored at loop cycles 0..wr_n-1, and bytes expected on the line.
    logic [7:0] wr_bytes  [0:15];
    int         wr_n;
    logic [7:0] exp_bytes [0:15];
    int         exp_n;

    mmio_uart_tx #(
        .BASE_ADDR    (32'h0000_1000),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .addr    (addr),
        .wd      (wd),
        .hit     (hit),
        .rd      (rd),
        .tx      (tx)
`ifdef UART_TX_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    always #5 clk = ~clk;

    // Expected line level in cycle c when the first byte was stored in cycle 0:
    // the start bit of the first frame begins in cycle 2, frames are contiguous.
    function automatic logic exp_tx(input int c);
        int rel;
        int s;
        rel = c - 2;
        if (rel < 0 || rel >= exp_n * FRAME) return 1'b1;
        s = (rel % FRAME) / CPB;
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        return exp_bytes[rel / FRAME][s - 1];
    endfunction

    task automatic peek(input logic [31:0] a, output logic [31:0] r, output logic h);
        addr = a;
        #1;
        r    = rd;
        h    = hit;
        addr = '0;
    endtask

    task automatic drive_writes(input int c);
        we   = 1'b0;
        addr = '0;
        wd   = '0;
        if (c < wr_n) begin
            we   = 1'b1;
            addr = 32'h0000_1000;
            wd   = {24'hC0FFEE, wr_bytes[c]};
        end
    endtask

    task automatic drive_one(input logic [31:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        wd   = d;
    endtask

    task automatic test_reset;
        logic [31:0] r;
        logic        h;
        reset_n = 1'b0;
        we = 1'b0; addr = '0; wd = '0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
        peek(32'h1004, r, h);
        n_checks++;
        if (r !== 32'h2) $display("FAIL reset_status: got %h want %h", r, 32'h2); else n_pass++;
        n_checks++;
        if (h !== 1'b1) $display("FAIL reset_hit: got %b want 1", h); else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame;
        logic [31:0] r;
        logic        h;
        wr_n = 1; wr_bytes[0] = 8'h55;
        exp_n = 1; exp_bytes[0] = 8'h55;
        for (int c = 0; c <= 45; c++) begin
            n_checks++;
            if (tx !== exp_tx(c)) $display("FAIL single_tx c=%0d: got %b want %b", c, tx, exp_tx(c));
            else n_pass++;
            if (c == 41) begin
                peek(32'h1004, r, h);
                n_checks++;
                if (r !== 32'h6) $display("FAIL single_busy_stop: got %h want %h", r, 32'h6); else n_pass++;
            end
            if (c == 42) begin
                peek(32'h1004, r, h);
                n_checks++;
                if (r !== 32'h2) $display("FAIL single_idle_after: got %h want %h", r, 32'h2); else n_pass++;
            end
            drive_writes(c);
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r;
        logic        h;
        wr_n = 2; wr_bytes[0] = 8'hA5; wr_bytes[1] = 8'h3C;
        exp_n = 2; exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h3C;
        for (int c = 0; c <= 85; c++) begin
            n_checks++;
            if (tx !== exp_tx(c)) $display("FAIL b2b_tx c=%0d: got %b want %b", c, tx, exp_tx(c));
            else n_pass++;
            if (c == 2) begin
                peek(32'h1004, r, h);
                n_checks++;
                if (r !== 32'h104) $display("FAIL b2b_count1: got %h want %h", r, 32'h104); else n_pass++;
            end
            if (c == 82) begin
                peek(32'h1004, r, h);
                n_checks++;
                if (r !== 32'h2) $display("FAIL b2b_idle_after: got %h want %h", r, 32'h2); else n_pass++;
            end
            drive_writes(c);
            @(negedge clk);
        end
    endtask

    task automatic test_burst9;
        logic [31:0] r;
        logic        h;
        logic [7:0]  pat [0:8];
        pat = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h7E, 8'h12, 8'hE8};
        wr_n = 9; exp_n = 9;
        for (int i = 0; i < 9; i++) begin
            wr_bytes[i]  = pat[i];
            exp_bytes[i] = pat[i];
        end
        for (int c = 0; c <= 364; c++) begin
            n_checks++;
            if (tx !== exp_tx(c)) $display("FAIL burst9_tx c=%0d: got %b want %b", c, tx, exp_tx(c));
            else n_pass++;
            if (c == 9) begin
                // 8 queued after the first byte left early: full, no overflow.
                peek(32'h1004, r, h);
                n_checks++;
                if (r !== 32'h805) $display("FAIL burst9_full_no_ovf: got %h want %h", r, 32'h805); else n_pass++;
            end
            if (c == 363) begin
                peek(32'h1004, r, h);
                n_checks++;
                if (r !== 32'h2) $display("FAIL burst9_drained: got %h want %h", r, 32'h2); else n_pass++;
            end
            drive_writes(c);
            @(negedge clk);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] r;
        logic        h;
        logic [7:0]  pat [0:9];
        pat = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87, 8'h98, 8'hAA};
        wr_n = 10; exp_n = 9;
        for (int i = 0; i < 10; i++) wr_bytes[i] = pat[i];
        for (int i = 0; i < 9; i++) exp_bytes[i] = pat[i];
        for (int c = 0; c <= 365; c++) begin
            n_checks++;
            if (tx !== exp_tx(c)) $display("FAIL ovf_tx c=%0d: got %b want %b", c, tx, exp_tx(c));
            else n_pass++;
            if (c == 10) begin
                peek(32'h1004, r, h);
                n_checks++;
                if (r !== 32'h80D) $display("FAIL ovf_set: got %h want %h", r, 32'h80D); else n_pass++;
            end
            if (c == 11) begin
                peek(32'h1004, r, h);
                n_checks++;
                if (r !== 32'h805) $display("FAIL ovf_clear: got %h want %h", r, 32'h805); else n_pass++;
            end
            if (c == 42) begin
                // Store in cycle 41 met a full FIFO while the STOP pop happened.
                peek(32'h1004, r, h);
                n_checks++;
                if (r !== 32'h70C) $display("FAIL ovf_push_during_pop: got %h want %h", r, 32'h70C); else n_pass++;
            end
            if (c == 363) begin
                peek(32'h1004, r, h);
                n_checks++;
                if (r !== 32'hA) $display("FAIL ovf_sticky: got %h want %h", r, 32'hA); else n_pass++;
            end
            if (c == 364) begin
                peek(32'h1004, r, h);
                n_checks++;
                if (r !== 32'h2) $display("FAIL ovf_clear_idle: got %h want %h", r, 32'h2); else n_pass++;
            end
            drive_writes(c);
            if (c == 10 || c == 363) drive_one(32'h1004, 32'h8);
            if (c == 41) drive_one(32'h1000, 32'h0000_00EE);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] r;
        logic        h;
        wr_n = 2; wr_bytes[0] = 8'h00; wr_bytes[1] = 8'h11;
        exp_n = 2; exp_bytes[0] = 8'h00; exp_bytes[1] = 8'h11;
        for (int c = 0; c <= 9; c++) begin
            n_checks++;
            if (tx !== exp_tx(c)) $display("FAIL rstmid_tx c=%0d: got %b want %b", c, tx, exp_tx(c));
            else n_pass++;
            drive_writes(c);
            @(negedge clk);
        end
        n_checks++;
        if (tx !== 1'b0) $display("FAIL rstmid_data_low: got %b want 0", tx); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1) $display("FAIL rstmid_tx_high: got %b want 1", tx); else n_pass++;
        peek(32'h1004, r, h);
        n_checks++;
        if (r !== 32'h2) $display("FAIL rstmid_status: got %h want %h", r, 32'h2); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            n_checks++;
            if (tx !== 1'b1) $display("FAIL rstmid_quiet c=%0d: got %b want 1", c, tx); else n_pass++;
        end
    endtask

    task automatic test_decode;
        logic [31:0] r;
        logic        h;
        logic [31:0] ctrl_exp;
        peek(32'h100C, r, h);
        n_checks++;
        if (h !== 1'b0) $display("FAIL dec_100c_hit: got %b want 0", h); else n_pass++;
        n_checks++;
        if (r !== 32'h0) $display("FAIL dec_100c_rd: got %h want 0", r); else n_pass++;
        peek(32'h2000, r, h);
        n_checks++;
        if (h !== 1'b0) $display("FAIL dec_2000_hit: got %b want 0", h); else n_pass++;
        n_checks++;
        if (r !== 32'h0) $display("FAIL dec_2000_rd: got %h want 0", r); else n_pass++;
        peek(32'h1000, r, h);
        n_checks++;
        if (h !== 1'b1 || r !== 32'h0) $display("FAIL dec_txdata_read: got hit=%b rd=%h want hit=1 rd=0", h, r);
        else n_pass++;
        // Stores outside the window must not queue anything.
        drive_one(32'h100C, 32'h55);
        @(negedge clk);
        drive_one(32'h2000, 32'h55);
        @(negedge clk);
        drive_one(32'h1008, 32'h1);
        @(negedge clk);
        we = 1'b0; addr = '0; wd = '0;
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) $display("FAIL dec_no_frame: got %b want 1", tx); else n_pass++;
        peek(32'h1004, r, h);
        n_checks++;
        if (r !== 32'h2 || h !== 1'b1) $display("FAIL dec_status_idle: got hit=%b rd=%h want hit=1 rd=2", h, r);
        else n_pass++;
`ifdef UART_TX_IRQ_EN
        ctrl_exp = 32'h1;
`else
        ctrl_exp = 32'h0;
`endif
        peek(32'h1008, r, h);
        n_checks++;
        if (r !== ctrl_exp || h !== 1'b1) $display("FAIL dec_ctrl: got hit=%b rd=%h want hit=1 rd=%h", h, r, ctrl_exp);
        else n_pass++;
    endtask

`ifdef UART_TX_IRQ_EN
    task automatic test_irq;
        logic want;
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL irq_idle: got %b want 1", irq); else n_pass++;
        wr_n = 1; wr_bytes[0] = 8'h41;
        exp_n = 1; exp_bytes[0] = 8'h41;
        for (int c = 0; c <= 45; c++) begin
            want = !(c >= 2 && c <= 42);
            n_checks++;
            if (irq !== want) $display("FAIL irq_c%0d: got %b want %b", c, irq, want); else n_pass++;
            n_checks++;
            if (tx !== exp_tx(c)) $display("FAIL irq_tx c=%0d: got %b want %b", c, tx, exp_tx(c));
            else n_pass++;
            drive_writes(c);
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_burst9();
        test_overflow();
        test_reset_mid_frame();
        test_decode();
`ifdef UART_TX_IRQ_EN
        test_irq();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
